// File: rtl/pic_pkg.sv
// Shared state encoding, opcode constant and level/one-hot helpers for the PIC sequencer.
// PIC_POLL_MODE_EN adds the POLL state.
package pic_pkg;

  localparam int unsigned MAX_IRQ     = 16;
  localparam logic [7:0]  CALL_OPCODE = 8'hCD;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    ACK2,
    ACK3
`ifdef PIC_POLL_MODE_EN
    , POLL
`endif
  } pic_state_e;

  // Helpers work at the widest legal N_IRQ; callers size-cast to their own width.
  function automatic logic [MAX_IRQ-1:0] num2onehot(input logic [3:0] num);
    num2onehot      = '0;
    num2onehot[num] = 1'b1;
  endfunction

  function automatic logic [3:0] onehot2num(input logic [MAX_IRQ-1:0] vec);
    onehot2num = '0;
    for (int unsigned i = 0; i < MAX_IRQ; i++) begin
      if (vec[i]) onehot2num = 4'(i);
    end
  endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// CPU-side bus of the PIC sequencer: INTA handshake, interrupt line, data and cascade buses.
interface pic_ack_sequencer_if #(
  parameter int unsigned CAS_W = 3
);
  logic             inta_n;
  logic             int_o;
  logic [7:0]       data_out;
  logic             data_oe;
  logic [CAS_W-1:0] cascade_in;
  logic [CAS_W-1:0] cascade_out;
  logic             cascade_oe;

  modport master (
    input  inta_n, cascade_in,
    output int_o, data_out, data_oe, cascade_out, cascade_oe
  );

  modport slave (
    output inta_n, cascade_in,
    input  int_o, data_out, data_oe, cascade_out, cascade_oe
  );
endinterface

// File: rtl/pic_vector_gen.sv
// Combinational byte generator for the acknowledge states (and poll read with PIC_POLL_MODE_EN).
module pic_vector_gen
  import pic_pkg::*;
#(
  parameter  int unsigned N_IRQ = 8,
  localparam int unsigned LVL_W = $clog2(N_IRQ)
) (
  input  pic_state_e       state,
  input  logic             mode_8086,
  input  logic             adi,
  input  logic [15:0]      base_addr,
  input  logic [LVL_W-1:0] lvl,
`ifdef PIC_POLL_MODE_EN
  input  logic             poll_rd,
  input  logic             poll_valid,
`endif
  output logic [7:0]       vec_byte,
  output logic             vec_drive
);

  logic [15:0] call_addr;

  // 8080 CALL target wraps at 16 bits; interval is 4 or 8 bytes per level.
  assign call_addr = base_addr + (16'(lvl) << (adi ? 4'd2 : 4'd3));

  always_comb begin
    vec_byte  = '0;
    vec_drive = 1'b0;
    case (state)
      ACK1: begin
        if (!mode_8086) begin
          vec_byte  = CALL_OPCODE;
          vec_drive = 1'b1;
        end
      end
      ACK2: begin
        vec_drive = 1'b1;
        vec_byte  = mode_8086 ? {base_addr[7:LVL_W], lvl} : call_addr[7:0];
      end
      ACK3: begin
        if (!mode_8086) begin
          vec_byte  = call_addr[15:8];
          vec_drive = 1'b1;
        end
      end
`ifdef PIC_POLL_MODE_EN
      POLL: begin
        if (poll_rd) begin
          vec_byte  = {poll_valid, {(7-LVL_W){1'b0}}, lvl};
          vec_drive = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// INTA pulse sequencer (8080/8086), vector/cascade driver and ISR/IRR/EOI strobe generator.
// Optional feature macro: PIC_POLL_MODE_EN (adds poll_cmd port and POLL state).
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter  int unsigned N_IRQ = 8,
  parameter  int unsigned CAS_W = 3,
  localparam int unsigned LVL_W = $clog2(N_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  pic_ack_sequencer_if.master bus,
  input  logic               sp_en_n,
  input  logic               mode_8086,
  input  logic               aeoi,
  input  logic               auto_rotate,
  input  logic               adi,
  input  logic               sngl,
  input  logic [N_IRQ-1:0]   cascade_cfg,
  input  logic [15:0]        base_addr,
  input  logic               irq_valid,
  input  logic [LVL_W-1:0]   irq_level,
  input  logic [N_IRQ-1:0]   isr_top,
  input  logic               eoi_cmd,
  input  logic               eoi_specific,
  input  logic [LVL_W-1:0]   eoi_level,
`ifdef PIC_POLL_MODE_EN
  input  logic               poll_cmd,
`endif
  output logic               freeze,
  output logic [N_IRQ-1:0]   latch_isr,
  output logic [N_IRQ-1:0]   clear_irr,
  output logic [N_IRQ-1:0]   eoi,
  output logic [LVL_W-1:0]   prio_rotate
);

  pic_state_e       state_q, state_d;
  logic             inta_s_q, inta_d_q;
  logic [LVL_W-1:0] lvl_q, lvl_d, rot_q, rot_d;
  logic             spur_q, spur_d, mcas_q, mcas_d, int_q, int_d;
  logic [N_IRQ-1:0] latch_q, latch_d, eoi_q, eoi_d;
  logic [7:0]       data_q, data_d;
  logic             oe_q, oe_d;
  logic             fall, rise, done, bus_ok, in_ack;
  logic [7:0]       vec_byte;
  logic             vec_drive;
`ifdef PIC_POLL_MODE_EN
  logic             poll_rd_q, poll_rd_d, poll_v_q, poll_v_d;
`endif

  assign fall   = inta_d_q & ~inta_s_q;
  assign rise   = ~inta_d_q & inta_s_q;
  assign in_ack = (state_q == ACK1) || (state_q == ACK2) || (state_q == ACK3);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    mcas_d  = mcas_q;
    latch_d = '0;
    done    = 1'b0;
`ifdef PIC_POLL_MODE_EN
    poll_rd_d = poll_rd_q;
    poll_v_d  = poll_v_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = ACK1;
          // No request at acknowledge time: answer as the lowest level, nothing to latch.
          if (irq_valid) begin
            lvl_d   = irq_level;
            spur_d  = 1'b0;
            latch_d = N_IRQ'(num2onehot(4'(irq_level)));
          end else begin
            lvl_d  = LVL_W'(N_IRQ - 1);
            spur_d = 1'b1;
          end
          mcas_d = sp_en_n & ~sngl & cascade_cfg[lvl_d];
        end
`ifdef PIC_POLL_MODE_EN
        else if (poll_cmd) begin
          state_d   = POLL;
          poll_rd_d = 1'b0;
        end
`endif
      end
      ACK1: if (fall) state_d = ACK2;
      ACK2: begin
        if (mode_8086) begin
          if (rise) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end else if (fall) begin
          state_d = ACK3;
        end
      end
      ACK3: begin
        if (rise) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
`ifdef PIC_POLL_MODE_EN
      POLL: begin
        if (!poll_rd_q && fall) begin
          poll_rd_d = 1'b1;
          poll_v_d  = irq_valid;
          lvl_d     = irq_level;
          if (irq_valid) latch_d = N_IRQ'(num2onehot(4'(irq_level)));
        end else if (poll_rd_q && rise) begin
          state_d   = IDLE;
          poll_rd_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Command EOI and AEOI may land in the same cycle; AEOI owns the rotate value then.
  always_comb begin
    eoi_d = '0;
    rot_d = rot_q;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        eoi_d = N_IRQ'(num2onehot(4'(eoi_level)));
      end else if (|isr_top) begin
        eoi_d = isr_top;
        if (auto_rotate) rot_d = LVL_W'(onehot2num(16'(isr_top)));
      end
    end
    if (done && aeoi && !spur_q) begin
      eoi_d = eoi_d | N_IRQ'(num2onehot(4'(lvl_q)));
      if (auto_rotate) rot_d = lvl_q;
    end
  end

  always_comb begin
    if (done)                 int_d = 1'b0;
    else if (state_d == IDLE) int_d = irq_valid;
    else                      int_d = int_q;
  end

  pic_vector_gen #(
    .N_IRQ(N_IRQ)
  ) u_vector_gen (
    .state     (state_q),
    .mode_8086 (mode_8086),
    .adi       (adi),
    .base_addr (base_addr),
    .lvl       (lvl_q),
`ifdef PIC_POLL_MODE_EN
    .poll_rd   (poll_rd_q),
    .poll_valid(poll_v_q),
`endif
    .vec_byte  (vec_byte),
    .vec_drive (vec_drive)
  );

  // A cascading master leaves the data bus to the slave; a slave drives only when addressed.
  always_comb begin
    bus_ok = sp_en_n ? ~mcas_q : (sngl | (bus.cascade_in == cascade_cfg[CAS_W-1:0]));
    data_d = vec_byte;
    oe_d   = vec_drive & ~inta_s_q & bus_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      inta_s_q <= 1'b1;
      inta_d_q <= 1'b1;
      lvl_q    <= '0;
      rot_q    <= LVL_W'(N_IRQ - 1);
      spur_q   <= 1'b0;
      mcas_q   <= 1'b0;
      int_q    <= 1'b0;
      latch_q  <= '0;
      eoi_q    <= '0;
      data_q   <= '0;
      oe_q     <= 1'b0;
`ifdef PIC_POLL_MODE_EN
      poll_rd_q <= 1'b0;
      poll_v_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      inta_s_q <= bus.inta_n;
      inta_d_q <= inta_s_q;
      lvl_q    <= lvl_d;
      rot_q    <= rot_d;
      spur_q   <= spur_d;
      mcas_q   <= mcas_d;
      int_q    <= int_d;
      latch_q  <= latch_d;
      eoi_q    <= eoi_d;
      data_q   <= data_d;
      oe_q     <= oe_d;
`ifdef PIC_POLL_MODE_EN
      poll_rd_q <= poll_rd_d;
      poll_v_q  <= poll_v_d;
`endif
    end
  end

  assign freeze          = (state_q != IDLE);
  assign latch_isr       = latch_q;
  assign clear_irr       = latch_q;
  assign eoi             = eoi_q;
  assign prio_rotate     = rot_q;
  assign bus.int_o       = int_q;
  assign bus.data_out    = data_q;
  assign bus.data_oe     = oe_q;
  assign bus.cascade_oe  = mcas_q & in_ack;
  assign bus.cascade_out = (mcas_q & in_ack) ? CAS_W'(lvl_q) : '0;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: directed scenarios plus randomized acknowledge cycles.
module tb_pic_ack_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         sp_en_n, mode_8086, aeoi, auto_rotate, adi, sngl;
  logic [N-1:0] cascade_cfg, isr_top;
  logic [15:0]  base_addr;
  logic         irq_valid, eoi_cmd, eoi_specific;
  logic [2:0]   irq_level, eoi_level;
`ifdef PIC_POLL_MODE_EN
  logic         poll_cmd;
`endif
  logic         freeze;
  logic [N-1:0] latch_isr, clear_irr, eoi;
  logic [2:0]   prio_rotate;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rot_m = N - 1;

  always #5 clk = ~clk;

  pic_ack_sequencer_if #(.CAS_W(CW)) bus ();

  pic_ack_sequencer #(.N_IRQ(N), .CAS_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .sp_en_n     (sp_en_n),
    .mode_8086   (mode_8086),
    .aeoi        (aeoi),
    .auto_rotate (auto_rotate),
    .adi         (adi),
    .sngl        (sngl),
    .cascade_cfg (cascade_cfg),
    .base_addr   (base_addr),
    .irq_valid   (irq_valid),
    .irq_level   (irq_level),
    .isr_top     (isr_top),
    .eoi_cmd     (eoi_cmd),
    .eoi_specific(eoi_specific),
    .eoi_level   (eoi_level),
`ifdef PIC_POLL_MODE_EN
    .poll_cmd    (poll_cmd),
`endif
    .freeze      (freeze),
    .latch_isr   (latch_isr),
    .clear_irr   (clear_irr),
    .eoi         (eoi),
    .prio_rotate (prio_rotate)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_int_o",   32'(bus.int_o), 0);
    check("rst_freeze",  32'(freeze), 0);
    check("rst_latch",   32'(latch_isr), 0);
    check("rst_clear",   32'(clear_irr), 0);
    check("rst_eoi",     32'(eoi), 0);
    check("rst_rotate",  32'(prio_rotate), N - 1);
    check("rst_data",    32'(bus.data_out), 0);
    check("rst_data_oe", 32'(bus.data_oe), 0);
    check("rst_cas_out", 32'(bus.cascade_out), 0);
    check("rst_cas_oe",  32'(bus.cascade_oe), 0);
  endtask

  // One full acknowledge cycle, expectations derived from the bus protocol arithmetic.
  // stop_at < pulse count leaves inta_n low after checking that pulse.
  task automatic run_ack(input logic m86, input logic a, input logic [15:0] base,
                         input int unsigned lv, input logic ae, input logic ar,
                         input logic sg, input logic [7:0] cfg, input logic valid,
                         input int unsigned stop_at);
    int unsigned elvl, npulse, nlat, nev;
    logic        casc;
    logic [15:0] addr;
    logic [7:0]  exp_b [3];
    logic        exp_d [3];
    logic [N-1:0] lat, clr, ev, exp_eoi;

    step();
    mode_8086 = m86; adi = a; base_addr = base; aeoi = ae; auto_rotate = ar;
    sngl = sg; cascade_cfg = cfg; irq_valid = valid; irq_level = 3'(lv);
    elvl   = valid ? lv : N - 1;
    casc   = !sg && cfg[elvl];
    npulse = m86 ? 2 : 3;
    addr   = base + 16'(elvl * (a ? 4 : 8));
    if (m86) begin
      exp_b[0] = 8'h00; exp_d[0] = 1'b0;
      exp_b[1] = (base[7:0] & 8'hF8) | 8'(elvl); exp_d[1] = 1'b1;
      exp_b[2] = 8'h00; exp_d[2] = 1'b0;
    end else begin
      exp_b[0] = 8'hCD;      exp_d[0] = 1'b1;
      exp_b[1] = addr[7:0];  exp_d[1] = 1'b1;
      exp_b[2] = addr[15:8]; exp_d[2] = 1'b1;
    end
    if (casc) begin
      exp_d[0] = 1'b0; exp_d[1] = 1'b0; exp_d[2] = 1'b0;
    end

    step();
    @(negedge clk);
    check("int_o_pre", 32'(bus.int_o), 32'(valid));

    for (int p = 0; p < int'(npulse); p++) begin
      step();
      bus.inta_n = 1'b0;
      lat = '0; clr = '0; nlat = 0;
      repeat (4) begin
        @(negedge clk);
        lat |= latch_isr;
        clr |= clear_irr;
        if (latch_isr != '0) nlat++;
      end
      check("data_oe", 32'(bus.data_oe), 32'(exp_d[p]));
      if (exp_d[p]) check("data_out", 32'(bus.data_out), 32'(exp_b[p]));
      check("freeze_ack", 32'(freeze), 1);
      check("cas_oe", 32'(bus.cascade_oe), 32'(casc));
      check("cas_out", 32'(bus.cascade_out), casc ? elvl : 0);
      if (p == 0) begin
        check("latch_isr", 32'(lat), valid ? (32'd1 << elvl) : 0);
        check("clear_irr", 32'(clr), valid ? (32'd1 << elvl) : 0);
        check("latch_len", nlat, valid ? 1 : 0);
        irq_valid = 1'b0;
        irq_level = 3'($urandom);
      end
      if (p == int'(stop_at)) return;
      step();
      bus.inta_n = 1'b1;
      if (p != int'(npulse) - 1) repeat (3) step();
    end

    ev = '0; nev = 0;
    repeat (4) begin
      @(negedge clk);
      ev |= eoi;
      if (eoi != '0) nev++;
    end
    exp_eoi = (ae && valid) ? N'(1 << elvl) : '0;
    if (ae && valid && ar) rot_m = elvl;
    check("aeoi", 32'(ev), 32'(exp_eoi));
    check("aeoi_len", nev, (exp_eoi != '0) ? 1 : 0);
    check("rotate", 32'(prio_rotate), rot_m);
    check("freeze_end", 32'(freeze), 0);
    check("data_oe_end", 32'(bus.data_oe), 0);
    check("cas_oe_end", 32'(bus.cascade_oe), 0);
    check("int_o_end", 32'(bus.int_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inta_n = 1'b1; bus.cascade_in = '0;
    sp_en_n = 1'b1; mode_8086 = 1'b0; aeoi = 1'b0; auto_rotate = 1'b0; adi = 1'b0;
    sngl = 1'b1; cascade_cfg = '0; base_addr = '0; irq_valid = 1'b0; irq_level = '0;
    isr_top = '0; eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
`ifdef PIC_POLL_MODE_EN
    poll_cmd = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #2 check_reset_vals();
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // 8086, base 0x40, level 5 -> 0x45
    run_ack(1'b1, 1'b0, 16'h0040, 5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 99);
    // 8080, adi, base 0x1000, level 3 -> CD 0C 10
    run_ack(1'b0, 1'b1, 16'h1000, 3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 99);
    // AEOI with rotation, level 2
    run_ack(1'b1, 1'b0, 16'h0080, 2, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 99);
    // cascading master, slave on IR3
    run_ack(1'b0, 1'b0, 16'h0300, 3, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 99);

    // request withdrawn before the pulse: int_o drops, spurious lowest-level vector
    step();
    irq_valid = 1'b1; irq_level = 3'd2;
    step();
    @(negedge clk);
    check("int_o_up", 32'(bus.int_o), 1);
    run_ack(1'b1, 1'b0, 16'h0040, 0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 99);

    // non-specific EOI with rotation
    step();
    isr_top = 8'h10; eoi_specific = 1'b0; auto_rotate = 1'b1; eoi_cmd = 1'b1;
    @(negedge clk);
    check("eoi_ns_early", 32'(eoi), 0);
    step();
    eoi_cmd = 1'b0;
    @(negedge clk);
    check("eoi_ns", 32'(eoi), 32'h10);
    rot_m = 4;
    check("rotate_ns", 32'(prio_rotate), rot_m);
    step();
    @(negedge clk);
    check("eoi_ns_len", 32'(eoi), 0);

    // non-specific EOI with nothing in service
    step();
    isr_top = '0; eoi_cmd = 1'b1;
    step();
    eoi_cmd = 1'b0;
    @(negedge clk);
    check("eoi_empty", 32'(eoi), 0);
    check("rotate_empty", 32'(prio_rotate), rot_m);

    // specific EOI
    step();
    auto_rotate = 1'b0; eoi_specific = 1'b1; eoi_level = 3'd6; eoi_cmd = 1'b1;
    step();
    eoi_cmd = 1'b0;
    @(negedge clk);
    check("eoi_spec", 32'(eoi), 32'h40);

    // reset in ACK2 of an 8080 sequence, then a clean restart
    run_ack(1'b0, 1'b0, 16'h2000, 1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    rot_m = N - 1;
    step();
    bus.inta_n = 1'b1;
    step();
    reset_n = 1'b1;
    run_ack(1'b0, 1'b0, 16'h2000, 1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 99);

    for (int t = 0; t < 20; t++) begin
      run_ack(1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, N - 1),
              1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'b1, 99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
